// File: rtl/bp_cce_alu_arbiter.sv
// bp_cce_alu_arbiter
//
// Purpose:
//   Shares one CCE ALU between two requesters:
//     requester 0 - instruction-execute path
//     requester 1 - pending-bit / counter update engine
//   The block grants one accepted request per cycle. A requester can lock the
//   grant across a multi-op sequence. The ALU is combinational. Its result is
//   captured in a one-entry output buffer that has a valid/ready handshake.
//
// Optional feature (macro BP_CCE_ALU_ARB_RR_EN):
//   defined   - round-robin on ties while unlocked. A last-grant pointer
//               tracks the winner.
//   undefined - fixed priority on ties: requester 0 always wins.
//
// Handshake semantics:
//   Request side: request i is accepted in a cycle where
//   req_v_i[i] & req_ready_o[i]. req_ready_o depends combinationally on
//   req_v_i, the lock state, res_v_o and res_ready_i. Requesters must not make
//   req_v_i depend on req_ready_o.
//   Result side: the result is consumed on a cycle where res_v_o & res_ready_i.
//   The result fields stay stable while res_v_o & ~res_ready_i.
//
// Ports:
//   clk_i, reset_i       clock; asynchronous active-high reset
//   req_v_i[1:0]         per-requester request valid
//   req_ready_o[1:0]     per-requester accept (one-hot or zero)
//   req_lock_i[1:0]      hold the grant after this request when set
//   req_alu_v_i[1:0]     arithmetic op valid
//   req_br_v_i[1:0]      branch op valid
//   req_opd_a_i/_b_i     operands; requester i owns slice [i*width_p +: width_p]
//   req_alu_op_i[2]      arithmetic op per requester
//   req_br_op_i[2]       branch op per requester
//   res_v_o, res_ready_i output buffer handshake
//   res_o, res_br_o      registered ALU result / branch result
//   res_id_o             requester that produced the buffered result
//   dbg_lock_state_o     lock FSM state (0 unlocked, 1 locked to 0, 2 locked to 1)

package bp_cce_alu_arbiter_pkg;
    typedef enum logic [3:0] {
        e_add_op = 4'd0,
        e_sub_op = 4'd1,
        e_lsh_op = 4'd2,
        e_rsh_op = 4'd3,
        e_and_op = 4'd4,
        e_or_op  = 4'd5,
        e_xor_op = 4'd6,
        e_neg_op = 4'd7,
        e_not_op = 4'd8,
        e_inc_op = 4'd9,
        e_dec_op = 4'd10
    } bp_cce_inst_minor_alu_op_e;

    typedef enum logic [2:0] {
        e_beq_op = 3'd0,
        e_bne_op = 3'd1,
        e_blt_op = 3'd2,
        e_ble_op = 3'd3,
        e_bi_op  = 3'd4
    } bp_cce_inst_minor_branch_op_e;
endpackage

// Combinational CCE ALU. Results are modulo 2^width_p, and comparisons are
// unsigned. When an op-valid flag is low, its result is forced to zero.
module bp_cce_alu
    import bp_cce_alu_arbiter_pkg::*;
#(
    parameter width_p = "inv"
) (
    input  logic                         v_i,
    input  logic                         br_v_i,
    input  logic [width_p-1:0]           opd_a_i,
    input  logic [width_p-1:0]           opd_b_i,
    input  bp_cce_inst_minor_alu_op_e    alu_op_i,
    input  bp_cce_inst_minor_branch_op_e br_op_i,
    output logic [width_p-1:0]           res_o,
    output logic                         br_res_o
);
    always_comb begin
        res_o = '0;
        if (v_i) begin
            unique case (alu_op_i)
                e_add_op: res_o = opd_a_i + opd_b_i;
                e_sub_op: res_o = opd_a_i - opd_b_i;
                // A shift amount of width_p or more shifts everything out, giving 0.
                e_lsh_op: res_o = opd_a_i << opd_b_i;
                e_rsh_op: res_o = opd_a_i >> opd_b_i;
                e_and_op: res_o = opd_a_i & opd_b_i;
                e_or_op:  res_o = opd_a_i | opd_b_i;
                e_xor_op: res_o = opd_a_i ^ opd_b_i;
                e_neg_op: res_o = -opd_a_i;
                e_not_op: res_o = ~opd_a_i;
                e_inc_op: res_o = opd_a_i + width_p'(1);
                e_dec_op: res_o = opd_a_i - width_p'(1);
                default:  res_o = '0;
            endcase
        end
    end

    always_comb begin
        br_res_o = 1'b0;
        if (br_v_i) begin
            unique case (br_op_i)
                e_beq_op: br_res_o = (opd_a_i == opd_b_i);
                e_bne_op: br_res_o = (opd_a_i != opd_b_i);
                e_blt_op: br_res_o = (opd_a_i <  opd_b_i);
                e_ble_op: br_res_o = (opd_a_i <= opd_b_i);
                e_bi_op:  br_res_o = 1'b1;
                default:  br_res_o = 1'b0;
            endcase
        end
    end
endmodule

module bp_cce_alu_arbiter
    import bp_cce_alu_arbiter_pkg::*;
#(
    parameter width_p = "inv"
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [1:0]                   req_v_i,
    output logic [1:0]                   req_ready_o,
    input  logic [1:0]                   req_lock_i,
    input  logic [1:0]                   req_alu_v_i,
    input  logic [1:0]                   req_br_v_i,
    input  logic [2*width_p-1:0]         req_opd_a_i,
    input  logic [2*width_p-1:0]         req_opd_b_i,
    input  bp_cce_inst_minor_alu_op_e    req_alu_op_i [2],
    input  bp_cce_inst_minor_branch_op_e req_br_op_i  [2],
    output logic                         res_v_o,
    input  logic                         res_ready_i,
    output logic [width_p-1:0]           res_o,
    output logic                         res_br_o,
    output logic                         res_id_o,
    output logic [1:0]                   dbg_lock_state_o
);
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } lock_state_e;

    lock_state_e        r_state;
    logic               r_res_v;
    logic [width_p-1:0] r_res;
    logic               r_res_br;
    logic               r_res_id;
`ifdef BP_CCE_ALU_ARB_RR_EN
    logic               r_last_grant;
`endif

    logic [1:0]         w_grant;
    logic [1:0]         w_tie_grant;
    logic               w_buf_free;
    logic               w_acc;
    logic               w_id;
    logic               w_alu_v;
    logic               w_br_v;
    logic [width_p-1:0] w_opd_a;
    logic [width_p-1:0] w_opd_b;
    logic [width_p-1:0] w_alu_res;
    logic               w_alu_br;

    // The buffer can take a new entry if it is empty or is being drained now.
    assign w_buf_free = ~r_res_v | res_ready_i;

`ifdef BP_CCE_ALU_ARB_RR_EN
    // The requester that did not win last time wins the tie.
    assign w_tie_grant = r_last_grant ? 2'b01 : 2'b10;
`else
    assign w_tie_grant = 2'b01;
`endif

    // The lock owner is the only candidate. This holds even when the owner is
    // idle, so the other requester cannot slip in during a locked sequence.
    always_comb begin
        w_grant = 2'b00;
        unique case (r_state)
            LOCK0:   w_grant = {1'b0, req_v_i[0]};
            LOCK1:   w_grant = {req_v_i[1], 1'b0};
            default: w_grant = (&req_v_i) ? w_tie_grant : req_v_i;
        endcase
    end

    // A grant bit is only set for a valid requester, so any ready bit is an accept.
    assign req_ready_o = w_grant & {2{w_buf_free}};
    assign w_acc       = |req_ready_o;
    assign w_id        = req_ready_o[1];

    assign w_alu_v = w_acc & req_alu_v_i[w_id];
    assign w_br_v  = w_acc & req_br_v_i[w_id];
    assign w_opd_a = w_id ? req_opd_a_i[width_p +: width_p] : req_opd_a_i[0 +: width_p];
    assign w_opd_b = w_id ? req_opd_b_i[width_p +: width_p] : req_opd_b_i[0 +: width_p];

    bp_cce_alu #(
        .width_p (width_p)
    ) u_alu (
        .v_i      (w_alu_v),
        .br_v_i   (w_br_v),
        .opd_a_i  (w_opd_a),
        .opd_b_i  (w_opd_b),
        .alu_op_i (req_alu_op_i[w_id]),
        .br_op_i  (req_br_op_i[w_id]),
        .res_o    (w_alu_res),
        .br_res_o (w_alu_br)
    );

    // Lock FSM and output buffer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= UNLOCKED;
            r_res_v      <= 1'b0;
            r_res        <= '0;
            r_res_br     <= 1'b0;
            r_res_id     <= 1'b0;
`ifdef BP_CCE_ALU_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else if (w_acc) begin
            // The lock bit on each accepted request decides the next state.
            // A locked state only accepts its owner, so lock=0 from the owner
            // releases the lock.
            r_state      <= req_lock_i[w_id] ? (w_id ? LOCK1 : LOCK0) : UNLOCKED;
            r_res_v      <= 1'b1;
            r_res        <= w_alu_res;
            r_res_br     <= w_alu_br;
            r_res_id     <= w_id;
`ifdef BP_CCE_ALU_ARB_RR_EN
            r_last_grant <= w_id;
`endif
        end else if (res_ready_i) begin
            r_res_v      <= 1'b0;
        end
    end

    assign res_v_o          = r_res_v;
    assign res_o            = r_res;
    assign res_br_o         = r_res_br;
    assign res_id_o         = r_res_id;
    assign dbg_lock_state_o = r_state;
endmodule

// File: tb/tb_bp_cce_alu_arbiter.sv
module tb_bp_cce_alu_arbiter;
  import bp_cce_alu_arbiter_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  logic [1:0]                   req_v_i;
  logic [1:0]                   req_ready_o;
  logic [1:0]                   req_lock_i;
  logic [1:0]                   req_alu_v_i;
  logic [1:0]                   req_br_v_i;
  logic [2*W-1:0]               req_opd_a_i;
  logic [2*W-1:0]               req_opd_b_i;
  bp_cce_inst_minor_alu_op_e    req_alu_op_i [2];
  bp_cce_inst_minor_branch_op_e req_br_op_i  [2];
  logic                         res_v_o;
  logic                         res_ready_i;
  logic [W-1:0]                 res_o;
  logic                         res_br_o;
  logic                         res_id_o;
  logic [1:0]                   dbg_lock_state_o;

  bp_cce_alu_arbiter #(.width_p(W)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .req_v_i          (req_v_i),
    .req_ready_o      (req_ready_o),
    .req_lock_i       (req_lock_i),
    .req_alu_v_i      (req_alu_v_i),
    .req_br_v_i       (req_br_v_i),
    .req_opd_a_i      (req_opd_a_i),
    .req_opd_b_i      (req_opd_b_i),
    .req_alu_op_i     (req_alu_op_i),
    .req_br_op_i      (req_br_op_i),
    .res_v_o          (res_v_o),
    .res_ready_i      (res_ready_i),
    .res_o            (res_o),
    .res_br_o         (res_br_o),
    .res_id_o         (res_id_o),
    .dbg_lock_state_o (dbg_lock_state_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 none, else requester holding the lock; last: last granted requester
  int           m_owner;
  int           m_last;
  logic         m_v;
  logic [W-1:0] m_res;
  logic         m_br;
  logic         m_id;

  function automatic logic [W-1:0] alu_model(bp_cce_inst_minor_alu_op_e op, int a, int b);
    int r;
    case (op)
      e_add_op: r = a + b;
      e_sub_op: r = a - b;
      e_lsh_op: r = (b >= W) ? 0 : (a << b);
      e_rsh_op: r = (b >= W) ? 0 : (a >> b);
      e_and_op: r = a & b;
      e_or_op:  r = a | b;
      e_xor_op: r = a ^ b;
      e_neg_op: r = 0 - a;
      e_not_op: r = ~a;
      e_inc_op: r = a + 1;
      e_dec_op: r = a - 1;
      default:  r = 0;
    endcase
    return r[W-1:0];
  endfunction

  function automatic logic br_model(bp_cce_inst_minor_branch_op_e op, int a, int b);
    case (op)
      e_beq_op: return a == b;
      e_bne_op: return a != b;
      e_blt_op: return a < b;
      e_ble_op: return a <= b;
      e_bi_op:  return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] exp_ready();
    if (m_v && !res_ready_i) return 2'b00;
    if (m_owner == 0) return {1'b0, req_v_i[0]};
    if (m_owner == 1) return {req_v_i[1], 1'b0};
    if (req_v_i == 2'b11) begin
`ifdef BP_CCE_ALU_ARB_RR_EN
      return (m_last == 0) ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
    end
    return req_v_i;
  endfunction

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_owner = -1; m_last = 1; m_v = 1'b0; m_res = '0; m_br = 1'b0; m_id = 1'b0;
    end else begin
      logic [1:0] r;
      int id;
      r = exp_ready();
      if (r != 2'b00) begin
        id    = (r == 2'b10) ? 1 : 0;
        m_res = req_alu_v_i[id] ? alu_model(req_alu_op_i[id], int'(req_opd_a_i[id*W +: W]), int'(req_opd_b_i[id*W +: W])) : '0;
        m_br  = req_br_v_i[id] ? br_model(req_br_op_i[id], int'(req_opd_a_i[id*W +: W]), int'(req_opd_b_i[id*W +: W])) : 1'b0;
        m_id  = 1'(id);
        m_v   = 1'b1;
        m_owner = req_lock_i[id] ? id : -1;
        m_last  = id;
      end else if (res_ready_i) begin
        m_v = 1'b0;
      end
    end
  end

  // compare process: every cycle out of reset, mid-cycle
  always @(negedge clk) begin
    if (!reset_i) begin
      chk("cmp_ready", 32'(req_ready_o), 32'(exp_ready()));
      chk("cmp_res_v", 32'(res_v_o), 32'(m_v));
      if (m_v) begin
        chk("cmp_res", 32'(res_o), 32'(m_res));
        chk("cmp_res_br", 32'(res_br_o), 32'(m_br));
        chk("cmp_res_id", 32'(res_id_o), 32'(m_id));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req_v_i = '0; req_lock_i = '0; req_alu_v_i = '0; req_br_v_i = '0;
    req_opd_a_i = '0; req_opd_b_i = '0;
    for (int i = 0; i < 2; i++) begin
      req_alu_op_i[i] = e_add_op;
      req_br_op_i[i]  = e_beq_op;
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic lock, input logic av, input logic bv,
                         input bp_cce_inst_minor_alu_op_e aop, input bp_cce_inst_minor_branch_op_e bop,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_v_i[i] = v; req_lock_i[i] = lock; req_alu_v_i[i] = av; req_br_v_i[i] = bv;
    req_alu_op_i[i] = aop; req_br_op_i[i] = bop;
    req_opd_a_i[i*W +: W] = a; req_opd_b_i[i*W +: W] = b;
  endtask

  typedef struct {
    bp_cce_inst_minor_alu_op_e    aop;
    bp_cce_inst_minor_branch_op_e bop;
    logic                         av;
    logic                         bv;
    logic [W-1:0]                 a;
    logic [W-1:0]                 b;
    logic [W-1:0]                 r;
    logic                         br;
  } vec_t;

  vec_t vt[$];
  int   exp_tie [4];

  initial begin
    reset_i = 1'b1;
    res_ready_i = 1'b1;
    idle_all();
`ifdef BP_CCE_ALU_ARB_RR_EN
    exp_tie = '{0, 1, 0, 1};
`else
    exp_tie = '{0, 0, 0, 0};
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_v", 32'(res_v_o), 0);
    chk("rst_res", 32'(res_o), 0);
    chk("rst_res_br", 32'(res_br_o), 0);
    chk("rst_res_id", 32'(res_id_o), 0);
    chk("rst_lock", 32'(dbg_lock_state_o), 0);
    reset_i = 1'b0;

    // tie arbitration directly after reset: req0 OR, req1 XOR
    set_req(0, 1, 0, 1, 0, e_or_op,  e_beq_op, 8'hF0, 8'h0F);
    set_req(1, 1, 0, 1, 0, e_xor_op, e_beq_op, 8'hFF, 8'h0F);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("tie_id", 32'(res_id_o), 32'(exp_tie[k]));
      chk("tie_res", 32'(res_o), (exp_tie[k] == 0) ? 32'hFF : 32'hF0);
    end
    idle_all();
    step();

    // single add
    set_req(0, 1, 0, 1, 0, e_add_op, e_beq_op, 8'd5, 8'd3);
    #1 chk("add_ready", 32'(req_ready_o), 32'b01);
    step();
    chk("add_v", 32'(res_v_o), 1);
    chk("add_res", 32'(res_o), 8);
    chk("add_id", 32'(res_id_o), 0);
    idle_all();
    step();

    // backpressure: 9-2 accepted, then held for 3 cycles
    res_ready_i = 1'b0;
    set_req(0, 1, 0, 1, 0, e_sub_op, e_beq_op, 8'd9, 8'd2);
    step();
    set_req(0, 1, 0, 1, 0, e_add_op, e_beq_op, 8'd1, 8'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_v", 32'(res_v_o), 1);
      chk("bp_res", 32'(res_o), 7);
      chk("bp_ready", 32'(req_ready_o), 0);
      step();
    end
    res_ready_i = 1'b1;
    #1 chk("bp_drain_ready", 32'(req_ready_o), 32'b01);
    step();
    chk("bp_next_res", 32'(res_o), 2);
    chk("bp_next_v", 32'(res_v_o), 1);
    idle_all();
    step();

    // locked sequence owned by req1
    set_req(1, 1, 1, 1, 0, e_sub_op, e_beq_op, 8'd10, 8'd4);
    #1 chk("lk_ready0", 32'(req_ready_o), 32'b10);
    step();
    chk("lk_res", 32'(res_o), 6);
    chk("lk_id", 32'(res_id_o), 1);
    chk("lk_state", 32'(dbg_lock_state_o), 2);
    // owner withdraws: req0 must not be granted
    idle_all();
    set_req(0, 1, 0, 1, 0, e_add_op, e_beq_op, 8'd2, 8'd2);
    #1 chk("lk_withdraw_ready", 32'(req_ready_o), 0);
    step();
    chk("lk_withdraw_v", 32'(res_v_o), 0);
    chk("lk_held", 32'(dbg_lock_state_o), 2);
    set_req(1, 1, 0, 0, 1, e_add_op, e_beq_op, 8'd7, 8'd7);
    #1 chk("lk_ready1", 32'(req_ready_o), 32'b10);
    step();
    chk("lk_br", 32'(res_br_o), 1);
    chk("lk_br_res", 32'(res_o), 0);
    chk("lk_br_id", 32'(res_id_o), 1);
    set_req(1, 0, 0, 0, 0, e_add_op, e_beq_op, 8'd0, 8'd0);
    #1 chk("lk_release_ready", 32'(req_ready_o), 32'b01);
    step();
    chk("lk_req0_res", 32'(res_o), 4);
    chk("lk_req0_id", 32'(res_id_o), 0);
    idle_all();
    step();

    // directed op table through req1, back-to-back
    vt.push_back('{e_add_op, e_beq_op, 1, 0, 8'hFF, 8'h01, 8'h00, 0});
    vt.push_back('{e_sub_op, e_beq_op, 1, 0, 8'h00, 8'h01, 8'hFF, 0});
    vt.push_back('{e_lsh_op, e_beq_op, 1, 0, 8'h01, 8'h07, 8'h80, 0});
    vt.push_back('{e_lsh_op, e_beq_op, 1, 0, 8'h01, 8'h08, 8'h00, 0});
    vt.push_back('{e_rsh_op, e_beq_op, 1, 0, 8'h80, 8'h07, 8'h01, 0});
    vt.push_back('{e_rsh_op, e_beq_op, 1, 0, 8'hFF, 8'h09, 8'h00, 0});
    vt.push_back('{e_and_op, e_beq_op, 1, 0, 8'hCC, 8'hAA, 8'h88, 0});
    vt.push_back('{e_neg_op, e_beq_op, 1, 0, 8'h01, 8'h00, 8'hFF, 0});
    vt.push_back('{e_not_op, e_beq_op, 1, 0, 8'h0F, 8'h00, 8'hF0, 0});
    vt.push_back('{e_inc_op, e_beq_op, 1, 0, 8'hFF, 8'h00, 8'h00, 0});
    vt.push_back('{e_dec_op, e_beq_op, 1, 0, 8'h00, 8'h00, 8'hFF, 0});
    vt.push_back('{e_add_op, e_bne_op, 0, 1, 8'h03, 8'h04, 8'h00, 1});
    vt.push_back('{e_add_op, e_blt_op, 0, 1, 8'h03, 8'h04, 8'h00, 1});
    vt.push_back('{e_add_op, e_blt_op, 0, 1, 8'h04, 8'h03, 8'h00, 0});
    vt.push_back('{e_add_op, e_ble_op, 0, 1, 8'h04, 8'h04, 8'h00, 1});
    vt.push_back('{e_add_op, e_beq_op, 0, 1, 8'h01, 8'h02, 8'h00, 0});
    vt.push_back('{e_add_op, e_bi_op,  0, 1, 8'h00, 8'h09, 8'h00, 1});
    vt.push_back('{e_add_op, e_beq_op, 0, 0, 8'h05, 8'h05, 8'h00, 0});
    foreach (vt[k]) begin
      set_req(1, 1, 0, vt[k].av, vt[k].bv, vt[k].aop, vt[k].bop, vt[k].a, vt[k].b);
      step();
      chk("tbl_v", 32'(res_v_o), 1);
      chk("tbl_res", 32'(res_o), 32'(vt[k].r));
      chk("tbl_br", 32'(res_br_o), 32'(vt[k].br));
      chk("tbl_id", 32'(res_id_o), 1);
    end
    idle_all();
    step();

    // reset in the middle of a locked sequence with an unread result
    res_ready_i = 1'b0;
    set_req(0, 1, 1, 1, 0, e_add_op, e_beq_op, 8'd1, 8'd2);
    step();
    chk("rm_v", 32'(res_v_o), 1);
    chk("rm_state", 32'(dbg_lock_state_o), 1);
    idle_all();
    #2 reset_i = 1'b1;
    #1;
    chk("rm_v_cleared", 32'(res_v_o), 0);
    chk("rm_unlocked", 32'(dbg_lock_state_o), 0);
    step();
    reset_i = 1'b0;
    res_ready_i = 1'b1;
    set_req(0, 1, 0, 1, 0, e_or_op,  e_beq_op, 8'h30, 8'h03);
    set_req(1, 1, 0, 1, 0, e_xor_op, e_beq_op, 8'h30, 8'h03);
    #1 chk("rm_tie_ready", 32'(req_ready_o), 32'b01);
    step();
    chk("rm_tie_id", 32'(res_id_o), 0);
    chk("rm_tie_res", 32'(res_o), 32'h33);
    chk("rm_no_lock", 32'(dbg_lock_state_o), 0);
    idle_all();
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bp_cce_alu_arbiter.md
# bp_cce_alu_arbiter

Shares one CCE ALU between two requesters inside the CCE:
- Requester 0: the instruction-execute path.
- Requester 1: the pending-bit / counter update engine.

The block arbitrates between them with a round-robin or fixed-priority policy and supports locked multi-op sequences. It instantiates bp_cce_alu combinationally and registers the result into a one-entry output buffer with a valid/ready handshake.

## Interface
- width_p, default "inv" (must be overridden): operand and result width, passed through to bp_cce_alu.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  reset, asynchronous, active-high.
- req_v_i  in  2  per-requester request valid.
- req_ready_o  out  2  per-requester accept; a request is accepted when req_v_i[i] & req_ready_o[i].
- req_lock_i  in  2  per-requester lock. When set on an accepted request, the grant is held for that requester.
- req_alu_v_i  in  2  per-requester arithmetic op valid (drives ALU v_i).
- req_br_v_i  in  2  per-requester branch op valid (drives ALU br_v_i).
- req_opd_a_i, req_opd_b_i  in  2*width_p each  operands; requester i uses slice [i*width_p +: width_p].
- req_alu_op_i  in  2 x bp_cce_inst_minor_alu_op_e  arithmetic op per requester.
- req_br_op_i  in  2 x bp_cce_inst_minor_branch_op_e  branch op per requester.
- res_v_o  out  1  output buffer holds a result.
- res_ready_i  in  1  consumer takes the result.
- res_o  out  width_p  registered ALU result.
- res_br_o  out  1  registered branch result.
- res_id_o  out  1  requester that produced the result.

## Operation
- **Output buffer.** The buffer is free when ~res_v_o | res_ready_i. While it is not free, req_ready_o = 2'b00.
- **Lock state machine.**
  - States: UNLOCKED, LOCK0, LOCK1.
  - UNLOCKED -> LOCKi on an accepted request from i with req_lock_i[i]=1.
  - LOCKi -> UNLOCKED on an accepted request from i with req_lock_i[i]=0.
  - While in LOCKi, only requester i may be granted, regardless of the other's valid.
- **Grant in UNLOCKED.**
  - Single valid requester: that requester is granted.
  - Both valid: the policy in Configuration decides.
  - req_ready_o[i] = grant[i] & buffer free. At most one bit of req_ready_o is set per cycle.
- **ALU drive.** On the granted cycle, the granted requester's fields drive bp_cce_alu. When no request is accepted, the ALU v_i and br_v_i inputs are 0.
- **Result capture.** On acceptance, the buffer loads:
  - res_o <= ALU result;
  - res_br_o <= ALU branch result;
  - res_id_o <= granted index;
  - res_v_o <= 1.
- **Drain.** On res_ready_i with no new acceptance, res_v_o <= 0. Simultaneous drain and accept reloads the buffer and res_v_o stays 1.
- **Arithmetic.** Width, wrap-around and overflow are exactly those of bp_cce_alu: modulo 2^width_p, and shifts by an amount >= width_p yield 0.
- **Result when an op is not valid.**
  - req_alu_v_i=0 on an accepted request: res_o = 0.
  - req_br_v_i=0 on an accepted request: res_br_o = 0.
  - An accepted request with both flags 0 still produces a buffer entry with zeros.

## Timing
- **Reset values** (asynchronous): res_v_o=0, res_o=0, res_br_o=0, res_id_o=0, lock state UNLOCKED, round-robin last-grant pointer = 1 (requester 0 wins the first tie).
- **Combinational paths.**
  - req_ready_o depends combinationally on req_v_i, the lock state, res_v_o and res_ready_i.
  - Requesters must not make req_v_i depend on req_ready_o.
- **Latency.** Exactly 1 cycle from acceptance to res_v_o=1 with valid data.
- **Throughput.** One op per cycle while res_ready_i=1.
- **Stability.** res_o, res_br_o and res_id_o stay stable while res_v_o=1 & res_ready_i=0.
- **Withdrawn requests.** A requester may drop req_v_i without being accepted. If the lock owner is not requesting, no grant is issued and the lock is held.
- **Reset mid-operation.** An unread result is discarded and a held lock is released immediately.

## Configuration
- BP_CCE_ALU_ARB_RR_EN defined: round-robin on ties in UNLOCKED.
  - Grant goes to the requester that is not the last-granted one.
  - The last-grant pointer updates on every acceptance, including locked ones.
- Undefined: fixed priority on ties. Requester 0 always wins and the pointer is absent.
- Lock behaviour is identical in both builds.

## Test plan
- **Single add.** Cycle 0: req0 issues e_add_op with a=5, b=3, alu_v=1, res_ready_i=1. Required: req_ready_o=2'b01 in cycle 0; in cycle 1, res_v_o=1, res_o=8, res_id_o=0.
- **Tie arbitration.** Both requesters valid continuously after reset, res_ready_i=1; req0 issues e_or_op, req1 issues e_xor_op.
  - With BP_CCE_ALU_ARB_RR_EN: res_id_o sequence 0,1,0,1.
  - Without it: res_id_o sequence 0,0,0,0.
- **Backpressure.** res_ready_i=0 for 3 cycles after one accepted e_sub_op with 9-2. Required: res_v_o=1 and res_o=7 held, req_ready_o=2'b00. Raising res_ready_i with req0 valid drains the buffer and accepts the next op in the same cycle.
- **Locked sequence.** req1 issues e_sub_op 10-4 with lock=1 while req0 is valid. Then req1 issues e_beq_op 7,7 with lock=0. Required: results 6 (id 1), then res_br_o=1 (id 1); req0 is accepted only on the following cycle.
- **Reset mid-operation.** Assert reset_i mid-cycle while res_v_o=1 in LOCK0. Required: res_v_o=0 before the next edge; after reset, a tie grants req0 and no lock is held.
